// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One access in flight at a time: IDLE -> BUSY (ACCESS_CYCLES) -> RESP -> IDLE.
module dmem_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               last;
    logic               id_q;
    logic               grant_c;
    logic               win_c;
    logic               done_c;

    // State and access counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, arbitration and end-of-access detection
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_c   = 1'b0;
        done_c    = 1'b0;
        win_c     = (req0 & req1) ? ~last : req1;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_c   = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_W'(ACCESS_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done_c    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs; the memory strobe registers double as the latched operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            id_q      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt0    <= grant_c & ~win_c;
            gnt1    <= grant_c & win_c;
            rvalid0 <= done_c & ~id_q;
            rvalid1 <= done_c & id_q;
            rdata   <= (done_c & ~mem_write) ? mem_rdata : '0;
            if (grant_c) begin
                last      <= win_c;
                id_q      <= win_c;
                mem_read  <= win_c ? ~we1 : ~we0;
                mem_write <= win_c ? we1 : we0;
                mem_addr  <= win_c ? addr1 : addr0;
                mem_wdata <= win_c ? wdata1 : wdata0;
            end else if (done_c) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts grant/strobe/response
// timing; a monitor compares every cycle. A second instance covers ACCESS_CYCLES=1.
module tb_dmem_arbiter;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        req0b, req1b, we0b, we1b;
    logic [31:0] addr0b, addr1b, wdata0b, wdata1b;
    logic        gnt0b, gnt1b, rvalid0b, rvalid1b, mem_read_b, mem_write_b;
    logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'd5) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    assign mem_rdata   = memfn(mem_addr);
    assign mem_rdata_b = memfn(mem_addr_b);

    dmem_arbiter #(.ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req0(req0b), .req1(req1b), .we0(we0b), .we1(we1b),
        .addr0(addr0b), .addr1(addr1b), .wdata0(wdata0b), .wdata1(wdata1b),
        .gnt0(gnt0b), .gnt1(gnt1b), .rvalid0(rvalid0b), .rvalid1(rvalid1b), .rdata(rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          g;
    } txn_t;

    txn_t        gq[$];
    txn_t        tq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    logic        p_req[2];
    logic        p_we[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];
    logic        m_last;
    int          free_edge;
    bit          hold_both;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_req(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
        p_req[r]   = 1'b1;
        p_we[r]    = we;
        p_addr[r]  = a;
        p_wdata[r] = d;
    endtask

    // Drive pins for the coming edge and predict what that edge does
    task automatic apply_and_model();
        int   w;
        int   e;
        txn_t t;
        req0   = p_req[0];
        req1   = p_req[1];
        we0    = p_req[0] ? p_we[0] : 1'($urandom);
        we1    = p_req[1] ? p_we[1] : 1'($urandom);
        addr0  = p_req[0] ? p_addr[0] : $urandom;
        addr1  = p_req[1] ? p_addr[1] : $urandom;
        wdata0 = p_req[0] ? p_wdata[0] : $urandom;
        wdata1 = p_req[1] ? p_wdata[1] : $urandom;
        e = cyc + 1;
        if (e >= free_edge && (p_req[0] || p_req[1])) begin
            if (p_req[0] && p_req[1]) w = m_last ? 0 : 1;
            else w = p_req[1] ? 1 : 0;
            t.id = w; t.we = p_we[w]; t.addr = p_addr[w]; t.wdata = p_wdata[w];
            t.rd = p_we[w] ? 32'd0 : memfn(p_addr[w]);
            t.g  = e;
            gq.push_back(t);
            tq.push_back(t);
            m_last    = (w == 1);
            free_edge = e + AC + 2;
            if (hold_both) new_req(w, 1'($urandom), $urandom_range(0, 63), $urandom);
            else p_req[w] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        apply_and_model();
    endtask

    task automatic drain();
        repeat (2 * (AC + 2) + 2) step();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} == 6'd0,
              32'({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}), 32'd0);
        check({name, "_data"}, (rdata | mem_addr | mem_wdata) == 32'd0,
              rdata | mem_addr | mem_wdata, 32'd0);
    endtask

    // Monitor: grants, memory strobes and responses against the scoreboard
    always @(posedge clk) begin
        txn_t        t;
        bit          active;
        logic [31:0] ea, ed;
        logic [1:0]  es;
        #1;
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", {gnt1, gnt0} == 2'b00, 32'({gnt1, gnt0}), 32'd0);
                end else begin
                    t = gq.pop_front();
                    check("gnt_id", {gnt1, gnt0} == ((t.id == 1) ? 2'b10 : 2'b01),
                          32'({gnt1, gnt0}), (t.id == 1) ? 32'd2 : 32'd1);
                    check("gnt_edge", cyc == t.g, 32'(cyc), 32'(t.g));
                end
            end else if (gq.size() != 0 && gq[0].g <= cyc) begin
                t = gq.pop_front();
                check("gnt_missing", {gnt1, gnt0} == ((t.id == 1) ? 2'b10 : 2'b01),
                      32'({gnt1, gnt0}), (t.id == 1) ? 32'd2 : 32'd1);
            end

            active = (tq.size() != 0) && (cyc >= tq[0].g) && (cyc < tq[0].g + AC);
            es = active ? {tq[0].we, ~tq[0].we} : 2'b00;
            ea = active ? tq[0].addr : 32'd0;
            ed = active ? tq[0].wdata : 32'd0;
            check("mem_strobes", {mem_write, mem_read} == es, 32'({mem_write, mem_read}), 32'(es));
            check("mem_addr", mem_addr == ea, mem_addr, ea);
            check("mem_wdata", mem_wdata == ed, mem_wdata, ed);

            if (rvalid0 || rvalid1) begin
                if (tq.size() == 0) begin
                    check("rvalid_unexpected", {rvalid1, rvalid0} == 2'b00, 32'({rvalid1, rvalid0}), 32'd0);
                end else begin
                    t = tq.pop_front();
                    check("rvalid_id", {rvalid1, rvalid0} == ((t.id == 1) ? 2'b10 : 2'b01),
                          32'({rvalid1, rvalid0}), (t.id == 1) ? 32'd2 : 32'd1);
                    check("rdata", rdata == t.rd, rdata, t.rd);
                    check("rvalid_edge", cyc == t.g + AC, 32'(cyc), 32'(t.g + AC));
                end
            end else begin
                check("rdata_idle", rdata == 32'd0, rdata, 32'd0);
                if (tq.size() != 0 && cyc >= tq[0].g + AC) begin
                    t = tq.pop_front();
                    check("rvalid_missing", {rvalid1, rvalid0} == ((t.id == 1) ? 2'b10 : 2'b01),
                          32'({rvalid1, rvalid0}), (t.id == 1) ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        p_req[0] = 1'b0; p_req[1] = 1'b0; p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = '0; p_addr[1] = '0; p_wdata[0] = '0; p_wdata[1] = '0;
        m_last = 1'b1; free_edge = 0; hold_both = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        req0b = 0; req1b = 0; we0b = 0; we1b = 0; addr0b = 0; addr1b = 0; wdata0b = 0; wdata1b = 0;

        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        apply_and_model();

        // ACCESS_CYCLES=1 instance: read of addr 7, request held to show the 3-cycle period
        @(negedge clk);
        req0b = 1'b1; addr0b = 32'd7; wdata0b = 32'h0BAD_F00D;
        @(posedge clk); #1;
        check("ac1_gnt", {gnt1b, gnt0b} == 2'b01, 32'({gnt1b, gnt0b}), 32'd1);
        check("ac1_strobe", {mem_write_b, mem_read_b} == 2'b01, 32'({mem_write_b, mem_read_b}), 32'd1);
        check("ac1_addr", mem_addr_b == 32'd7, mem_addr_b, 32'd7);
        check("ac1_wdata", mem_wdata_b == 32'h0BAD_F00D, mem_wdata_b, 32'h0BAD_F00D);
        @(posedge clk); #1;
        check("ac1_rvalid", {rvalid1b, rvalid0b, gnt0b} == 3'b010, 32'({rvalid1b, rvalid0b, gnt0b}), 32'd2);
        check("ac1_rdata", rdata_b == memfn(32'd7), rdata_b, memfn(32'd7));
        check("ac1_strobe_off", {mem_write_b, mem_read_b} == 2'b00, 32'({mem_write_b, mem_read_b}), 32'd0);
        @(posedge clk); #1;
        check("ac1_idle", {gnt0b, rvalid0b, rdata_b[0]} == 3'b000, 32'({gnt0b, rvalid0b}), 32'd0);
        @(posedge clk); #1;
        check("ac1_period", gnt0b == 1'b1, 32'(gnt0b), 32'd1);
        @(negedge clk);
        req0b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ac1_done", {gnt0b, gnt1b, rvalid0b, rvalid1b} == 4'd0,
              32'({gnt0b, gnt1b, rvalid0b, rvalid1b}), 32'd0);

        // Directed: read, write, contention, late request
        new_req(0, 1'b0, 32'd5, 32'h1111_2222);
        drain();
        new_req(1, 1'b1, 32'h10, 32'h1234);
        drain();
        hold_both = 1'b1;
        new_req(0, 1'b0, 32'd20, 32'hA);
        new_req(1, 1'b1, 32'd21, 32'hB);
        repeat (12) step();
        hold_both = 1'b0;
        drain();
        new_req(0, 1'b1, 32'd30, 32'hCAFE);
        step();
        step();
        new_req(1, 1'b0, 32'd31, 32'h0);
        drain();

        // Reset abort in the second BUSY cycle
        new_req(0, 1'b0, 32'd9, 32'h0);
        step();
        step();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_abort");
        gq.delete(); tq.delete();
        m_last = 1'b1; free_edge = 0;
        p_req[1] = 1'b0;
        new_req(0, 1'b0, 32'd11, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_and_model();
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++)
                if (!p_req[r] && $urandom_range(0, 3) == 0)
                    new_req(r, 1'($urandom), $urandom_range(0, 63), $urandom);
            step();
        end
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        drain();
        check("scoreboard_empty", (gq.size() + tq.size()) == 0, 32'(gq.size() + tq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
